// File: rtl/bus_initiator_pkg.sv
// Shared definitions for the 16-bit memory bus: widths, FSM encodings and default timing.
package busPkg;

  localparam int ADDR_W      = 32;
  localparam int DATA_W      = 16;
  localparam int TIMEOUT_DEF = 16;
  localparam int TURN_DEF    = 1;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_READ  = 3'd1;
  localparam logic [2:0] ST_WRITE = 3'd2;
  localparam logic [2:0] ST_RESP  = 3'd3;
  localparam logic [2:0] ST_TURN  = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_READ  = ST_READ,
    S_WRITE = ST_WRITE,
    S_RESP  = ST_RESP,
    S_TURN  = ST_TURN
  } state_e;

endpackage

// File: rtl/bus_wait_counter.sv
// Enable/clear counter that saturates at LIMIT; o_tc flags that the limit has been reached.
module bus_wait_counter #(
  parameter int WIDTH = 5,
  parameter int LIMIT = 15
) (
  input  logic clk,
  input  logic rstN,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  localparam logic [WIDTH-1:0] LIM = WIDTH'(LIMIT);

  logic [WIDTH-1:0] r_count;

  // NOTE: state is updated with <= so every flop samples pre-edge values, regardless of block order.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en && (r_count != LIM)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_tc = (r_count == LIM);

endmodule

// File: rtl/bus_initiator.sv
// Bus master: converts single-beat CPU loads/stores into bus cycles, with read timeout and
// a turnaround gap after every transaction.
module bus_initiator
  import busPkg::*;
#(
  parameter int TIMEOUT     = TIMEOUT_DEF,
  parameter int TURN_CYCLES = TURN_DEF
) (
  input  logic              clk,
  input  logic              rstN,
  input  logic              reqValid,
  output logic              reqReady,
  input  logic              reqWrite,
  input  logic [ADDR_W-1:0] reqAddr,
  input  logic [DATA_W-1:0] reqWdata,
  output logic              respValid,
  output logic [DATA_W-1:0] respRdata,
  output logic              respError,
  output logic [ADDR_W-1:0] address,
  inout  wire  [DATA_W-1:0] data,
  output logic              addressDataEn,
  output logic              writeEn,
  output logic              outputEn,
  input  logic              readDone
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam int TURN_W = $clog2(TURN_CYCLES + 1);
  localparam logic [TURN_W-1:0] TURN_LAST = TURN_W'(TURN_CYCLES - 1);

  state_e              r_state;
  state_e              w_next;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_error;
  logic                r_armed;
  logic [TURN_W-1:0]   r_turn_cnt;
  logic                w_tc;
  logic                w_read_done;

  // Z or X on readDone must never complete a read.
  assign w_read_done = (readDone == 1'b1);

  // Last READ cycle is READ cycle TIMEOUT-1, so a timed-out read spends exactly TIMEOUT cycles in READ.
  bus_wait_counter #(
    .WIDTH (WAIT_W),
    .LIMIT (TIMEOUT - 1)
  ) u_wait (
    .clk   (clk),
    .rstN  (rstN),
    .i_clr (r_state != S_READ),
    .i_en  (r_state == S_READ),
    .o_tc  (w_tc)
  );

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // NOTE: every output gets a default before the case, so no path through the block can infer a latch.
  always_comb begin
    w_next        = r_state;
    reqReady      = 1'b0;
    addressDataEn = 1'b0;
    writeEn       = 1'b0;
    outputEn      = 1'b0;
    respValid     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        reqReady = 1'b1;
        if (reqValid) w_next = reqWrite ? S_WRITE : S_READ;
      end
      S_READ: begin
        addressDataEn = 1'b1;
        outputEn      = 1'b1;
        if ((r_armed && w_read_done) || w_tc) w_next = S_RESP;
      end
      S_WRITE: begin
        addressDataEn = 1'b1;
        writeEn       = 1'b1;
        w_next        = S_RESP;
      end
      S_RESP: begin
        respValid = 1'b1;
        w_next    = S_TURN;
      end
      S_TURN: begin
        if (r_turn_cnt == TURN_LAST) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // NOTE: the datapath registers are reset too, so address and response outputs read 0 after reset.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_error    <= 1'b0;
      r_armed    <= 1'b0;
      r_turn_cnt <= '0;
    end else begin
      if ((r_state == S_IDLE) && reqValid) begin
        r_addr  <= reqAddr;
        r_wdata <= reqWdata;
      end
      // readDone in the first READ cycle still describes the previous bus cycle.
      r_armed <= (r_state == S_READ);
      if (r_state == S_READ) begin
        if (r_armed && w_read_done) begin
          r_rdata <= data;
          r_error <= 1'b0;
        end else if (w_tc) begin
          r_rdata <= '0;
          r_error <= 1'b1;
        end
      end else if (r_state == S_WRITE) begin
        r_rdata <= '0;
        r_error <= 1'b0;
      end
      if (r_state == S_TURN) begin
        r_turn_cnt <= r_turn_cnt + 1'b1;
      end else begin
        r_turn_cnt <= '0;
      end
    end
  end

  assign address   = r_addr;
  assign respRdata = r_rdata;
  assign respError = r_error;
  assign data      = writeEn ? r_wdata : {DATA_W{1'bz}};

endmodule

// File: tb/tb_bus_initiator.sv
// Self-checking bench for bus_initiator with a registered memory slave mapped at 0x0000_0000-0x0000_FFFF.
module tb_bus_initiator;

  logic        clk = 1'b0;
  logic        rstN;
  logic        reqValid;
  logic        reqReady;
  logic        reqWrite;
  logic [31:0] reqAddr;
  logic [15:0] reqWdata;
  logic        respValid;
  logic [15:0] respRdata;
  logic        respError;
  logic [31:0] address;
  wire  [15:0] data;
  logic        addressDataEn;
  logic        writeEn;
  logic        outputEn;
  wire         readDone;

  logic        stale;
  logic        slv_done;
  logic [15:0] slv_rdata;
  logic [15:0] mem [0:65535];

  int n_total = 0;
  int n_pass  = 0;

  bus_initiator dut (
    .clk           (clk),
    .rstN          (rstN),
    .reqValid      (reqValid),
    .reqReady      (reqReady),
    .reqWrite      (reqWrite),
    .reqAddr       (reqAddr),
    .reqWdata      (reqWdata),
    .respValid     (respValid),
    .respRdata     (respRdata),
    .respError     (respError),
    .address       (address),
    .data          (data),
    .addressDataEn (addressDataEn),
    .writeEn       (writeEn),
    .outputEn      (outputEn),
    .readDone      (readDone)
  );

  always #5 clk = ~clk;

  // Slave answers one cycle after it sees a read strobe, like a synchronous memory.
  always @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      slv_done  <= 1'b0;
      slv_rdata <= 16'h0;
    end else begin
      if (writeEn && addressDataEn && (address[31:16] == 16'h0)) mem[address[15:0]] <= data;
      slv_done  <= addressDataEn && outputEn && (address[31:16] == 16'h0);
      slv_rdata <= mem[address[15:0]];
    end
  end

  assign data     = (slv_done && outputEn) ? slv_rdata : 16'hzzzz;
  assign readDone = stale ? 1'b1 : (slv_done ? 1'b1 : 1'bz);

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic wait_ready(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (reqReady) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) check({name, "_ready_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int          k   = -1;
    int          wen = 0;
    logic [15:0] wd  = 16'h0;
    @(negedge clk);
    reqValid = 1'b1;
    reqWrite = v.write;
    reqAddr  = v.addr;
    reqWdata = v.wdata;
    wait_ready($sformatf("v%0d", idx));
    @(negedge clk);
    reqValid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (writeEn) begin
        wen++;
        wd = data;
      end
      if (respValid) begin
        k = i;
        break;
      end
      @(negedge clk);
    end
    check($sformatf("v%0d_latency", idx), k, v.exp_lat);
    check($sformatf("v%0d_rdata", idx), {16'h0, respRdata}, {16'h0, v.exp_rdata});
    check($sformatf("v%0d_error", idx), {31'h0, respError}, {31'h0, v.exp_err});
    check($sformatf("v%0d_wen_cycles", idx), wen, v.write ? 1 : 0);
    if (v.write) check($sformatf("v%0d_bus_wdata", idx), {16'h0, wd}, {16'h0, v.wdata});
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, acc_k, rv_cnt, rv_first, rv_last;

    for (int a = 0; a < 65536; a++) mem[a] = 16'h0;
    mem[16'h0010] = 16'hBEEF;
    mem[16'h0020] = 16'h0001;
    mem[16'h0021] = 16'h0002;

    //         write  addr           wdata     rdata     err   lat
    vecs[0] = '{1'b0, 32'h0000_0010, 16'h0000, 16'hBEEF, 1'b0, 2};
    vecs[1] = '{1'b1, 32'h0000_7FFF, 16'h1234, 16'h0000, 1'b0, 1};
    vecs[2] = '{1'b0, 32'h0000_7FFF, 16'h0000, 16'h1234, 1'b0, 2};
    vecs[3] = '{1'b0, 32'h0001_0000, 16'h0000, 16'h0000, 1'b1, 16};
    vecs[4] = '{1'b0, 32'h0000_0020, 16'h0000, 16'h0001, 1'b0, 2};
    vecs[5] = '{1'b0, 32'h0000_0021, 16'h0000, 16'h0002, 1'b0, 2};
    vecs[6] = '{1'b1, 32'h0000_0020, 16'hABCD, 16'h0000, 1'b0, 1};
    vecs[7] = '{1'b0, 32'h0000_0020, 16'h0000, 16'hABCD, 1'b0, 2};
    vecs[8] = '{1'b0, 32'hFFFF_FFFF, 16'h0000, 16'h0000, 1'b1, 16};
    vecs[9] = '{1'b0, 32'h0000_0010, 16'h0000, 16'hBEEF, 1'b0, 2};

    rstN     = 1'b0;
    reqValid = 1'b0;
    reqWrite = 1'b0;
    reqAddr  = 32'h0;
    reqWdata = 16'h0;
    stale    = 1'b0;
    repeat (3) @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);
    check("rst_reqReady",  {31'h0, reqReady},      32'd1);
    check("rst_respValid", {31'h0, respValid},     32'd0);
    check("rst_respRdata", {16'h0, respRdata},     32'd0);
    check("rst_respError", {31'h0, respError},     32'd0);
    check("rst_adEn",      {31'h0, addressDataEn}, 32'd0);
    check("rst_writeEn",   {31'h0, writeEn},       32'd0);
    check("rst_outputEn",  {31'h0, outputEn},      32'd0);
    check("rst_address",   address,                32'd0);

    for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

    // Stale readDone held high during READ cycle 0 must not complete the load.
    @(negedge clk);
    reqValid = 1'b1;
    reqWrite = 1'b0;
    reqAddr  = 32'h0000_0021;
    wait_ready("stale");
    @(negedge clk);
    reqValid = 1'b0;
    stale    = 1'b1;
    check("stale_k0_respValid", {31'h0, respValid}, 32'd0);
    @(negedge clk);
    stale = 1'b0;
    check("stale_k1_respValid", {31'h0, respValid}, 32'd0);
    check("stale_k1_outputEn",  {31'h0, outputEn},  32'd1);
    @(negedge clk);
    check("stale_k2_respValid", {31'h0, respValid}, 32'd1);
    check("stale_k2_rdata",     {16'h0, respRdata}, 32'h0002);

    // Asynchronous reset during READ cycle 1.
    @(negedge clk);
    reqValid = 1'b1;
    reqAddr  = 32'h0000_0010;
    wait_ready("rstmid");
    @(negedge clk);
    reqValid = 1'b0;
    check("rstmid_k0_outputEn", {31'h0, outputEn}, 32'd1);
    @(posedge clk);
    #2;
    rstN = 1'b0;
    #1;
    check("rstmid_outputEn_async", {31'h0, outputEn},      32'd0);
    check("rstmid_adEn_async",     {31'h0, addressDataEn}, 32'd0);
    acc = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (respValid) acc++;
    end
    rstN = 1'b1;
    @(posedge clk);
    #1;
    check("rstmid_reqReady", {31'h0, reqReady},  32'd1);
    check("rstmid_rdata",    {16'h0, respRdata}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (respValid) acc++;
    end
    check("rstmid_no_resp", acc, 32'd0);

    // Store request held through RESP/TURN of a load: accepted once, only in IDLE.
    @(negedge clk);
    reqValid = 1'b1;
    reqWrite = 1'b0;
    reqAddr  = 32'h0000_0010;
    wait_ready("hold");
    @(negedge clk);
    reqWrite = 1'b1;
    reqAddr  = 32'h0000_0030;
    reqWdata = 16'h5555;
    acc = 0; acc_k = -1; rv_cnt = 0; rv_first = -1; rv_last = -1;
    for (int i = 0; i < 16; i++) begin
      if (acc > 0) reqValid = 1'b0;
      if (reqValid && reqReady) begin
        acc++;
        acc_k = i;
      end
      if (respValid) begin
        rv_cnt++;
        if (rv_first < 0) rv_first = i;
        rv_last = i;
      end
      @(negedge clk);
    end
    check("hold_accepts",    acc,      32'd1);
    check("hold_accept_k",   acc_k,    32'd4);
    check("hold_resp_count", rv_cnt,   32'd2);
    check("hold_load_resp",  rv_first, 32'd2);
    check("hold_store_resp", rv_last,  32'd6);
    check("hold_mem_0x30",   {16'h0, mem[16'h0030]}, 32'h5555);
    check("hold_store_err",  {31'h0, respError},     32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
